// File: rtl/dmem_pkg.sv
// Shared types and default parameters for the data memory responder.
package dmem_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int LATENCY_DEF = 5;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_latency_counter.sv
// Loadable down-counter with a zero flag; pacing for the memory stall window.
module dmem_latency_counter
  import dmem_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/data_memory.sv
// Byte-addressed data memory that stalls the CPU via busywait for LATENCY+1 cycles.
// Define DMEM_CLEAR_ON_RESET_EN to have reset also clear the whole array.
module data_memory
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = LATENCY_DEF   // legal range 1..15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                op_write_q, op_write_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;
  logic mem_we;

  dmem_latency_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .dec        (cnt_dec),
    .load_value (LOAD_VAL),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    readdata_d = readdata_q;
    busywait   = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      IDLE: begin
        busywait = read | write;
        if (read || write) begin
          state_d    = BUSY;
          cnt_load   = 1'b1;
          addr_d     = address;
          wdata_d    = writedata;
          // a simultaneous read wins; the write is dropped
          op_write_d = ~read;
        end
      end
      BUSY: begin
        busywait = 1'b1;
        if (cnt_zero) begin
          state_d = DONE;
          if (op_write_q) begin
            mem_we = 1'b1;
          end else begin
            readdata_d = mem_q[addr_q];
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
      readdata_q <= readdata_d;
    end
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end
`else
  // array has no reset; the reset term only blocks a write racing a reset edge
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[addr_q] <= wdata_q;
    end
  end
`endif

  assign readdata = readdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: LATENCY=5 instance plus a LATENCY=1 instance.
module tb_data_memory;

  logic       clock = 1'b0;
  logic       reset;
  logic       rd    [2];
  logic       wr    [2];
  logic [7:0] addr  [2];
  logic [7:0] wd    [2];
  logic [7:0] rdata [2];
  logic       busy  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  data_memory #(.ADDR_W(8), .DATA_W(8), .LATENCY(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .read      (rd[0]),
    .write     (wr[0]),
    .address   (addr[0]),
    .writedata (wd[0]),
    .readdata  (rdata[0]),
    .busywait  (busy[0])
  );

  data_memory #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) dut1 (
    .clock     (clock),
    .reset     (reset),
    .read      (rd[1]),
    .write     (wr[1]),
    .address   (addr[1]),
    .writedata (wd[1]),
    .readdata  (rdata[1]),
    .busywait  (busy[1])
  );

  typedef struct {
    logic       r;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one request at a negedge, counts busywait-high cycles, returns readdata
  // sampled in the first non-stalled cycle, then drops the request.
  task automatic access(input int u, input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, output int stall, output logic [7:0] rv);
    @(negedge clock);
    rd[u] = r; wr[u] = w; addr[u] = a; wd[u] = d;
    #1;
    stall = 0;
    while (busy[u] === 1'b1 && stall < 40) begin
      stall++;
      @(negedge clock);
      #1;
    end
    rv = rdata[u];
    rd[u] = 1'b0;
    wr[u] = 1'b0;
  endtask

  initial begin
    int         n;
    logic [7:0] v;

    vecs[0]  = '{1'b0, 1'b1, 8'h3C, 8'hA5, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5};
    vecs[2]  = '{1'b0, 1'b1, 8'h20, 8'h11, 8'hA5};
    vecs[3]  = '{1'b1, 1'b1, 8'h20, 8'hFF, 8'h11};
    vecs[4]  = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h11};
    vecs[5]  = '{1'b0, 1'b1, 8'h05, 8'h77, 8'h11};
    vecs[6]  = '{1'b0, 1'b1, 8'h06, 8'h88, 8'h11};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h5A, 8'h11};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A};
    vecs[9]  = '{1'b0, 1'b1, 8'hFF, 8'hC3, 8'h5A};
    vecs[10] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3};
    vecs[11] = '{1'b1, 1'b0, 8'h3C, 8'h00, 8'hA5};

    for (int u = 0; u < 2; u++) begin
      rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = 8'h00; wd[u] = 8'h00;
    end
    reset = 1'b1;
    #1;
    check("reset_busywait", busy[0], 1'b0);
    check("reset_readdata", rdata[0], 8'h00);
    rd[0] = 1'b1;
    #1;
    check("reset_busywait_follows_req", busy[0], 1'b1);
    rd[0] = 1'b0;
    @(negedge clock);
    reset = 1'b0;

`ifdef DMEM_CLEAR_ON_RESET_EN
    access(0, 1'b1, 1'b0, 8'h10, 8'h00, n, v);
    check("cleared_read_stall", n, 6);
    check("cleared_read_data", v, 8'h00);
`endif

    for (int i = 0; i < 12; i++) begin
      access(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, n, v);
      check($sformatf("vec%0d_stall", i), n, 6);
      check($sformatf("vec%0d_readdata", i), v, vecs[i].exp_rd);
    end

    // address changed mid-BUSY must not affect the captured access
    @(negedge clock);
    rd[0] = 1'b1; addr[0] = 8'h05;
    #1;
    n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin
        addr[0] = 8'h06;
        wd[0]   = 8'hEE;
      end
      @(negedge clock);
      #1;
    end
    check("addr_change_stall", n, 6);
    check("addr_change_data", rdata[0], 8'h77);
    rd[0] = 1'b0;

    // read held through DONE: DONE ignores it, following IDLE starts a fresh access
    @(negedge clock);
    rd[0] = 1'b1; addr[0] = 8'h3C;
    #1;
    n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
      #1;
    end
    check("held_first_stall", n, 6);
    check("held_done_busywait", busy[0], 1'b0);
    check("held_first_data", rdata[0], 8'hA5);
    @(negedge clock);
    #1;
    n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      n++;
      @(negedge clock);
      #1;
    end
    check("held_second_stall", n, 6);
    check("held_second_data", rdata[0], 8'hA5);
    rd[0] = 1'b0;

    // reset in the third BUSY cycle of a write discards it
    access(0, 1'b0, 1'b1, 8'h09, 8'h01, n, v);
    check("pre_write_stall", n, 6);
    @(negedge clock);
    wr[0] = 1'b1; addr[0] = 8'h09; wd[0] = 8'h42;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    #1;
    check("midwrite_busywait_high", busy[0], 1'b1);
    reset = 1'b1;
    wr[0] = 1'b0;
    #1;
    check("midwrite_reset_busywait", busy[0], 1'b0);
    check("midwrite_reset_readdata", rdata[0], 8'h00);
    @(negedge clock);
    reset = 1'b0;
    access(0, 1'b1, 1'b0, 8'h09, 8'h00, n, v);
    check("post_reset_read_stall", n, 6);
`ifdef DMEM_CLEAR_ON_RESET_EN
    check("post_reset_read_09", v, 8'h00);
`else
    check("post_reset_read_09", v, 8'h01);
    access(0, 1'b1, 1'b0, 8'h3C, 8'h00, n, v);
    check("persist_read_3c", v, 8'hA5);
`endif

    // LATENCY=1 instance
    access(1, 1'b0, 1'b1, 8'hFE, 8'h3D, n, v);
    check("lat1_write_stall", n, 2);
    check("lat1_write_readdata_held", v, 8'h00);
    access(1, 1'b1, 1'b0, 8'hFE, 8'h00, n, v);
    check("lat1_read_stall", n, 2);
    check("lat1_read_data", v, 8'h3D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressed data memory for the 8-bit single-cycle processor. It acts as the responder to the CPU's load/store requests. It stalls the CPU through a busywait handshake for a fixed number of clock cycles, then completes the read or write. It sits beside the register file and ALU on the CPU's memory port; operand selection and forwarding stay entirely on the CPU side.

## Interface
Parameters:
- ADDR_W, 8, address width; depth is 2^ADDR_W bytes
- DATA_W, 8, data word width
- LATENCY, 5, stall cycles per access (legal range 1..15)

Ports:
- clock  in  1  single system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- read  in  1  load request, level, held by CPU until busywait low
- write  in  1  store request, level, held by CPU until busywait low
- address  in  ADDR_W  byte address of the access
- writedata  in  DATA_W  store data
- readdata  out  DATA_W  load result, registered
- busywait  out  1  stall request to CPU

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - busywait = read | write (combinational), so the CPU stalls in the same cycle it raises the request.
  - On a clock edge with read or write high: capture address, writedata and operation; load the counter with LATENCY-1; go to BUSY.
  - Read has priority: if read and write are both high, the access is a read and the write is dropped.
- BUSY:
  - busywait = 1.
  - Each edge: if counter == 0, complete the access and go to DONE; otherwise decrement the counter.
  - Completing a read loads readdata from mem[captured address].
  - Completing a write sets mem[captured address] = captured writedata; readdata is unchanged.
- DONE:
  - busywait = 0; read and write are ignored for this one cycle.
  - Next edge: go to IDLE.
- Changes to address, writedata, read or write during BUSY have no effect on the captured access.
- Reset (async, any state):
  - state = IDLE, counter = 0, readdata = 0.
  - busywait follows the IDLE rule immediately.
  - A pending write is discarded.
  - Array contents are governed by Configuration.

## Timing
- The request is raised in cycle 0 and sampled at the end of cycle 0.
- busywait is high in cycles 0..LATENCY, which is LATENCY+1 stalled cycles.
- Cycle LATENCY+1: busywait is low and readdata is valid.
  - The CPU samples readdata and drops read/write at the end of this cycle.
- A back-to-back request can be sampled at the earliest at the end of cycle LATENCY+2, which is the first IDLE cycle.
- Write visibility: a read whose request is sampled after a write's DONE cycle returns the new data.
- readdata holds its value between reads.
- readdata changes only on read completion or reset.

## Configuration
- DMEM_CLEAR_ON_RESET_EN
  - Defined: reset assertion clears all 2^ADDR_W locations to 0 in addition to the FSM reset.
  - Undefined: reset affects only the FSM, counter and readdata; array contents persist across reset and are X in simulation until written.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - default ADDR_W, DATA_W and LATENCY;
  - the counter width constant (4 bits).
- Sub-module dmem_latency_counter: loadable down-counter with a zero flag, driven by the FSM load and decrement strobes.
- The array and FSM stay in data_memory.

## Test plan
- Reset with DMEM_CLEAR_ON_RESET_EN defined, then read address 0x10 -> busywait high for exactly 6 cycles (LATENCY=5), then readdata = 0x00 with busywait low.
- Write 0xA5 to 0x3C, then read 0x3C -> each access stalls 6 cycles; the read returns 0xA5.
- Read and write both high at 0x20 with writedata 0xFF, after a prior write of 0x11 -> treated as a read; returns 0x11; mem[0x20] is still 0x11.
- Change address from 0x05 to 0x06 mid-BUSY on a read of 0x05 (mem[0x05]=0x77, mem[0x06]=0x88) -> readdata = 0x77.
- Assert reset in the 3rd BUSY cycle of a write of 0x42 to 0x09 (macro undefined, mem[0x09]=0x01) -> busywait drops with the request low; readdata = 0; a later read of 0x09 returns 0x01.
- LATENCY=1 build: write then read 0xFE -> busywait high for 2 cycles per access; readdata is correct in cycle 2.
